// File: rtl/laser_spot_finder.sv
// laser_spot_finder
// Raster-scans a frame buffer through a registered read port (data arrives
// one cycle after the address). It finds the brightest pixel at or above a
// latched threshold and counts every qualifying pixel.
// Optional build macro: SPOT_CENTROID_EN. When defined, sum_x/sum_y
// accumulate the coordinates of qualifying pixels. When undefined, those
// outputs are tied to zero and no accumulator hardware is built.
// The frame geometry must satisfy FRAME_W <= 256, FRAME_H <= 128 and
// FRAME_W*FRAME_H <= 32768 so that the coordinate and address ports can hold it.
module laser_spot_finder #(
   parameter int FRAME_W = 160,
   parameter int FRAME_H = 120
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [7:0]  threshold,
   output logic [14:0] frame_addr,
   input  logic [7:0]  frame_pixel,
   output logic        busy,
   output logic        done,
   output logic        spot_found,
   output logic [7:0]  spot_x,
   output logic [6:0]  spot_y,
   output logic [7:0]  spot_peak,
   output logic [14:0] spot_count,
   output logic [21:0] sum_x,
   output logic [21:0] sum_y
);

   localparam int          N         = FRAME_W * FRAME_H;
   localparam logic [14:0] ADDR_LAST = 15'(N - 1);
   localparam logic [7:0]  X_LAST    = 8'(FRAME_W - 1);
   localparam logic [14:0] COUNT_MAX = 15'h7fff;

   typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

   state_t      state_reg;
   logic [14:0] addr_reg;
   logic [7:0]  x_reg;
   logic [6:0]  y_reg;
   logic [7:0]  thr_reg;
   logic        busy_reg;
   logic        done_reg;

   // Compare stage: coordinates delayed one cycle to line up with frame_pixel.
   logic        pix_valid_reg;
   logic [7:0]  x_d_reg;
   logic [6:0]  y_d_reg;

   // Working accumulators for the scan in progress.
   logic        found_reg, found_next;
   logic [7:0]  peak_reg,  peak_next;
   logic [7:0]  px_reg,    px_next;
   logic [6:0]  py_reg,    py_next;
   logic [14:0] count_reg, count_next;

   // Published results. They change only when the FSM enters DONE.
   logic        res_found_reg;
   logic [7:0]  res_x_reg;
   logic [6:0]  res_y_reg;
   logic [7:0]  res_peak_reg;
   logic [14:0] res_count_reg;

   logic accept;
   logic qualify;

   // A start request is honoured only from IDLE. Requests seen while scanning
   // or while in DONE are dropped.
   assign accept  = (state_reg == IDLE) && start;
   assign qualify = pix_valid_reg && (frame_pixel >= thr_reg);

   // Next value of the working accumulators for the pixel now on frame_pixel.
   always_comb begin
      found_next = found_reg;
      peak_next  = peak_reg;
      px_next    = px_reg;
      py_next    = py_reg;
      count_next = count_reg;
      if (qualify) begin
         found_next = 1'b1;
         if (count_reg != COUNT_MAX) begin
            count_next = count_reg + 15'd1;
         end
         // A strict compare keeps the earliest pixel on ties. The first
         // qualifying pixel always loads, so a zero-valued spot with
         // threshold 0 still reports its own coordinates.
         if (!found_reg || (frame_pixel > peak_reg)) begin
            peak_next = frame_pixel;
            px_next   = x_d_reg;
            py_next   = y_d_reg;
         end
      end
   end

   // Control FSM: address generation, x/y tracking, busy/done flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         addr_reg  <= '0;
         x_reg     <= '0;
         y_reg     <= '0;
         thr_reg   <= '0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               done_reg <= 1'b0;
               if (start) begin
                  state_reg <= SCAN;
                  thr_reg   <= threshold;
                  busy_reg  <= 1'b1;
                  addr_reg  <= '0;
                  x_reg     <= '0;
                  y_reg     <= '0;
               end
            end
            SCAN: begin
               if (addr_reg == ADDR_LAST) begin
                  // The final pixel is still in flight from the buffer.
                  // DRAIN gives it one more cycle to reach the compare stage.
                  state_reg <= DRAIN;
                  addr_reg  <= '0;
                  x_reg     <= '0;
                  y_reg     <= '0;
               end else begin
                  addr_reg <= addr_reg + 15'd1;
                  if (x_reg == X_LAST) begin
                     x_reg <= '0;
                     y_reg <= y_reg + 7'd1;
                  end else begin
                     x_reg <= x_reg + 8'd1;
                  end
               end
            end
            DRAIN: begin
               state_reg <= DONE;
               busy_reg  <= 1'b0;
               done_reg  <= 1'b1;
            end
            DONE: begin
               state_reg <= IDLE;
               done_reg  <= 1'b0;
            end
            default: begin
               state_reg <= IDLE;
               busy_reg  <= 1'b0;
               done_reg  <= 1'b0;
            end
         endcase
      end
   end

   // Read-latency pipeline: a pixel is valid the cycle after its address was
   // presented in SCAN.
   always_ff @(posedge clk) begin
      if (rst) begin
         pix_valid_reg <= 1'b0;
         x_d_reg       <= '0;
         y_d_reg       <= '0;
      end else begin
         pix_valid_reg <= (state_reg == SCAN);
         x_d_reg       <= x_reg;
         y_d_reg       <= y_reg;
      end
   end

   // Working accumulators: cleared on an accepted start, otherwise follow next.
   always_ff @(posedge clk) begin
      if (rst || accept) begin
         found_reg <= 1'b0;
         peak_reg  <= '0;
         px_reg    <= '0;
         py_reg    <= '0;
         count_reg <= '0;
      end else begin
         found_reg <= found_next;
         peak_reg  <= peak_next;
         px_reg    <= px_next;
         py_reg    <= py_next;
         count_reg <= count_next;
      end
   end

   // Publish results on DRAIN->DONE. The next values are used so that the
   // last pixel, which is compared during DRAIN itself, is included.
   always_ff @(posedge clk) begin
      if (rst) begin
         res_found_reg <= 1'b0;
         res_x_reg     <= '0;
         res_y_reg     <= '0;
         res_peak_reg  <= '0;
         res_count_reg <= '0;
      end else if (state_reg == DRAIN) begin
         res_found_reg <= found_next;
         res_x_reg     <= px_next;
         res_y_reg     <= py_next;
         res_peak_reg  <= peak_next;
         res_count_reg <= count_next;
      end
   end

`ifdef SPOT_CENTROID_EN
   logic [21:0] acc_sx_reg, acc_sx_next;
   logic [21:0] acc_sy_reg, acc_sy_next;
   logic [21:0] res_sx_reg;
   logic [21:0] res_sy_reg;

   // Coordinate sums of qualifying pixels, for a host-side centroid.
   always_comb begin
      acc_sx_next = acc_sx_reg;
      acc_sy_next = acc_sy_reg;
      if (qualify) begin
         acc_sx_next = acc_sx_reg + 22'(x_d_reg);
         acc_sy_next = acc_sy_reg + 22'(y_d_reg);
      end
   end

   // Centroid accumulators and their published copies.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_sx_reg <= '0;
         acc_sy_reg <= '0;
         res_sx_reg <= '0;
         res_sy_reg <= '0;
      end else begin
         if (accept) begin
            acc_sx_reg <= '0;
            acc_sy_reg <= '0;
         end else begin
            acc_sx_reg <= acc_sx_next;
            acc_sy_reg <= acc_sy_next;
         end
         if (state_reg == DRAIN) begin
            res_sx_reg <= acc_sx_next;
            res_sy_reg <= acc_sy_next;
         end
      end
   end

   assign sum_x = res_sx_reg;
   assign sum_y = res_sy_reg;
`else
   assign sum_x = '0;
   assign sum_y = '0;
`endif

   assign frame_addr = addr_reg;
   assign busy       = busy_reg;
   assign done       = done_reg;
   assign spot_found = res_found_reg;
   assign spot_x     = res_x_reg;
   assign spot_y     = res_y_reg;
   assign spot_peak  = res_peak_reg;
   assign spot_count = res_count_reg;

endmodule

// File: tb/tb_laser_spot_finder.sv
// Testbench for laser_spot_finder. It uses a reduced frame height
// (160 x 8), so the full-width row wrap and the last-address corner are
// still covered while every scan stays short.
module tb_laser_spot_finder;

   localparam int FW = 160;
   localparam int FH = 8;
   localparam int N  = FW * FH;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  threshold;
   logic [14:0] frame_addr;
   logic [7:0]  frame_pixel;
   logic        busy;
   logic        done;
   logic        spot_found;
   logic [7:0]  spot_x;
   logic [6:0]  spot_y;
   logic [7:0]  spot_peak;
   logic [14:0] spot_count;
   logic [21:0] sum_x;
   logic [21:0] sum_y;

   int n_vec = 0;
   int n_bad = 0;

   logic [7:0] mem [N];

   always #5 clk = ~clk;

   // Frame buffer with a registered read port.
   always @(posedge clk) frame_pixel <= mem[int'(frame_addr)];

   laser_spot_finder #(.FRAME_W(FW), .FRAME_H(FH)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .threshold  (threshold),
      .frame_addr (frame_addr),
      .frame_pixel(frame_pixel),
      .busy       (busy),
      .done       (done),
      .spot_found (spot_found),
      .spot_x     (spot_x),
      .spot_y     (spot_y),
      .spot_peak  (spot_peak),
      .spot_count (spot_count),
      .sum_x      (sum_x),
      .sum_y      (sum_y)
   );

   typedef struct packed {
      logic        found;
      logic [7:0]  x;
      logic [6:0]  y;
      logic [7:0]  peak;
      logic [14:0] count;
      logic [21:0] sx;
      logic [21:0] sy;
   } res_t;

   typedef struct {
      string name;
      int    x0, y0, v0;
      int    x1, y1, v1;
      int    thr;
      res_t  exp;
   } vec_t;

   function automatic res_t mk(input logic f, input int x, input int y, input int peak,
                               input int cnt, input int sx, input int sy);
      res_t r;
      r.found = f;
      r.x     = 8'(x);
      r.y     = 7'(y);
      r.peak  = 8'(peak);
      r.count = 15'(cnt);
      r.sx    = 22'(sx);
      r.sy    = 22'(sy);
      return r;
   endfunction

   function automatic res_t grab();
      res_t r;
      r.found = spot_found;
      r.x     = spot_x;
      r.y     = spot_y;
      r.peak  = spot_peak;
      r.count = spot_count;
      r.sx    = sum_x;
      r.sy    = sum_y;
      return r;
   endfunction

   // Reference model, straight from the rules. First collect the count, the
   // maximum qualifying value and the coordinate sums. Then find the first
   // raster-order pixel that holds that maximum.
   function automatic res_t model(input logic [7:0] thr);
      res_t r;
      int   cnt;
      int   best;
      int   sx;
      int   sy;
      r    = '0;
      cnt  = 0;
      best = -1;
      sx   = 0;
      sy   = 0;
      for (int i = 0; i < N; i++) begin
         if (mem[i] >= thr) begin
            cnt++;
            sx += i % FW;
            sy += i / FW;
            if (int'(mem[i]) > best) best = int'(mem[i]);
         end
      end
      if (cnt > 0) begin
         r.found = 1'b1;
         r.peak  = 8'(best);
         for (int i = N - 1; i >= 0; i--) begin
            if (mem[i] >= thr && int'(mem[i]) == best) begin
               r.x = 8'(i % FW);
               r.y = 7'(i / FW);
            end
         end
      end
      r.count = 15'((cnt > 32767) ? 32767 : cnt);
      r.sx    = 22'(sx);
      r.sy    = 22'(sy);
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic check_res(input string tag, input res_t act, input res_t exp);
      chk({tag, ".found"}, 64'(act.found), 64'(exp.found));
      chk({tag, ".x"},     64'(act.x),     64'(exp.x));
      chk({tag, ".y"},     64'(act.y),     64'(exp.y));
      chk({tag, ".peak"},  64'(act.peak),  64'(exp.peak));
      chk({tag, ".count"}, 64'(act.count), 64'(exp.count));
`ifdef SPOT_CENTROID_EN
      chk({tag, ".sum_x"}, 64'(act.sx), 64'(exp.sx));
      chk({tag, ".sum_y"}, 64'(act.sy), 64'(exp.sy));
`else
      chk({tag, ".sum_x"}, 64'(act.sx), 64'd0);
      chk({tag, ".sum_y"}, 64'(act.sy), 64'd0);
`endif
   endtask

   task automatic clear_mem(input logic [7:0] v);
      for (int i = 0; i < N; i++) mem[i] = v;
   endtask

   task automatic put(input int x, input int y, input int v);
      mem[y * FW + x] = 8'(v);
   endtask

   // Starts a scan in cycle t and watches cycles t+1 .. t+N+3.
   // Timing is checked against the expected windows: busy in t+1..t+N+1,
   // done in t+N+2 only, and frame_addr counting 0..N-1 in t+1..t+N.
   // Optional events, given as cycle offsets from t (0 = unused):
   // a stray start pulse, a threshold change, and a one-cycle reset.
   task automatic run_scan(input string tag, input logic [7:0] thr, input int pulse_at,
                           input int chg_at, input logic [7:0] chg_thr, input int rst_at,
                           output res_t at_done, output res_t at_mid);
      int   busy_err;
      int   done_err;
      int   addr_err;
      int   exp_addr;
      logic exp_busy;
      logic exp_done;
      logic aborted;
      busy_err = 0;
      done_err = 0;
      addr_err = 0;
      at_done  = '0;
      at_mid   = '0;
      @(negedge clk);
      threshold = thr;
      start     = 1'b1;
      for (int k = 1; k <= N + 3; k++) begin
         @(negedge clk);
         start    = 1'b0;
         rst      = 1'b0;
         aborted  = (rst_at > 0) && (k > rst_at);
         exp_busy = !aborted && (k <= N + 1);
         exp_done = !aborted && (k == N + 2);
         exp_addr = (!aborted && k <= N) ? k - 1 : 0;
         if (busy !== exp_busy) busy_err++;
         if (done !== exp_done) done_err++;
         if (frame_addr !== 15'(exp_addr)) addr_err++;
         if (k == N + 2) at_done = grab();
         if (k == N / 2) at_mid = grab();
         if (aborted && k == rst_at + 1) check_res({tag, ".after_rst"}, grab(), '0);
         if (k == pulse_at) start = 1'b1;
         if (k == chg_at) threshold = chg_thr;
         if (k == rst_at) rst = 1'b1;
      end
      start = 1'b0;
      rst   = 1'b0;
      chk({tag, ".busy_window_errs"}, 64'(busy_err), 64'd0);
      chk({tag, ".done_window_errs"}, 64'(done_err), 64'd0);
      chk({tag, ".addr_seq_errs"},    64'(addr_err), 64'd0);
      $display("scan %s thr=%0d: found=%0d x=%0d y=%0d peak=%0d count=%0d sum_x=%0d sum_y=%0d",
               tag, thr, at_done.found, at_done.x, at_done.y, at_done.peak,
               at_done.count, at_done.sx, at_done.sy);
   endtask

   vec_t vecs [8];
   res_t got_done;
   res_t got_mid;
   res_t prev;
   res_t e;

   initial begin
      vecs[0] = '{"all_zero",     -1, 0,   0,  -1, 0,   0,  16, mk(1'b0,   0, 0,   0,    0,      0,    0)};
      vecs[1] = '{"single",       37, 5, 200,  -1, 0,   0, 100, mk(1'b1,  37, 5, 200,    1,     37,    5)};
      vecs[2] = '{"tie_first",    10, 5, 180,  90, 7, 180, 150, mk(1'b1,  10, 5, 180,    2,    100,   12)};
      vecs[3] = '{"last_addr",   159, 7, 128,  -1, 0,   0, 128, mk(1'b1, 159, 7, 128,    1,    159,    7)};
      vecs[4] = '{"brighter",      3, 0, 150, 100, 6, 220, 100, mk(1'b1, 100, 6, 220,    2,    103,    6)};
      vecs[5] = '{"first_addr",    0, 0, 255,  -1, 0,   0, 255, mk(1'b1,   0, 0, 255,    1,      0,    0)};
      vecs[6] = '{"below_thr",    50, 3,  99,  -1, 0,   0, 100, mk(1'b0,   0, 0,   0,    0,      0,    0)};
      vecs[7] = '{"thr0_all",     -1, 0,   0,  -1, 0,   0,   0, mk(1'b1,   0, 0,   0, 1280, 101760, 4480)};

      // Reset is held with start also high: reset must win.
      rst       = 1'b1;
      start     = 1'b1;
      threshold = 8'hff;
      clear_mem(8'd0);
      repeat (3) @(negedge clk);
      check_res("reset", grab(), '0);
      chk("reset.busy", 64'(busy), 64'd0);
      chk("reset.done", 64'(done), 64'd0);
      chk("reset.addr", 64'(frame_addr), 64'd0);
      rst   = 1'b0;
      start = 1'b0;
      @(negedge clk);
      chk("reset.idle_busy", 64'(busy), 64'd0);
      prev = '0;

      // Directed table.
      for (int i = 0; i < 8; i++) begin
         clear_mem(8'd0);
         if (vecs[i].x0 >= 0) put(vecs[i].x0, vecs[i].y0, vecs[i].v0);
         if (vecs[i].x1 >= 0) put(vecs[i].x1, vecs[i].y1, vecs[i].v1);
         run_scan(vecs[i].name, 8'(vecs[i].thr), 0, 0, 8'd0, 0, got_done, got_mid);
         check_res({vecs[i].name, ".done"}, got_done, vecs[i].exp);
         check_res({vecs[i].name, ".hold"}, got_mid, prev);
         prev = vecs[i].exp;
      end

      // A stray start at t+500 and a threshold drop at t+700 must not matter.
      clear_mem(8'd0);
      put(20, 2, 120);
      put(30, 3, 90);
      e = mk(1'b1, 20, 2, 120, 1, 20, 2);
      run_scan("restart_ignored", 8'd100, 500, 700, 8'd50, 0, got_done, got_mid);
      check_res("restart_ignored.done", got_done, e);
      check_res("restart_ignored.hold", got_mid, prev);
      prev = e;

      // A start while in DONE is dropped.
      e = mk(1'b1, 20, 2, 120, 2, 50, 5);
      run_scan("start_in_done", 8'd80, N + 2, 0, 8'd0, 0, got_done, got_mid);
      check_res("start_in_done.done", got_done, e);
      repeat (3) @(negedge clk);
      chk("start_in_done.busy_after", 64'(busy), 64'd0);
      chk("start_in_done.done_after", 64'(done), 64'd0);
      prev = e;

      // Reset mid-scan aborts without a done pulse and clears all results.
      run_scan("rst_abort", 8'd80, 0, 0, 8'd0, 1000, got_done, got_mid);
      check_res("rst_abort.hold", got_mid, prev);
      prev = '0;

      // The next scan after the abort completes normally.
      e = mk(1'b1, 20, 2, 120, 1, 20, 2);
      run_scan("after_rst", 8'd100, 0, 0, 8'd0, 0, got_done, got_mid);
      check_res("after_rst.done", got_done, e);
      check_res("after_rst.hold", got_mid, prev);
      prev = e;

      // Randomized frames: dim noise with a few hot pixels, random threshold.
      for (int ri = 0; ri < 8; ri++) begin
         int         hot;
         logic [7:0] thr;
         for (int i = 0; i < N; i++) mem[i] = 8'($urandom_range(0, 90));
         hot = int'($urandom_range(0, 6));
         for (int j = 0; j < hot; j++) mem[int'($urandom_range(0, N - 1))] = 8'($urandom_range(91, 255));
         thr = 8'($urandom_range(40, 255));
         e = model(thr);
         run_scan($sformatf("rand%0d", ri), thr, 0, 0, 8'd0, 0, got_done, got_mid);
         check_res($sformatf("rand%0d.done", ri), got_done, e);
         check_res($sformatf("rand%0d.hold", ri), got_mid, prev);
         prev = e;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/laser_spot_finder.md
LASER_SPOT_FINDER -- requirements
Module: laser_spot_finder

Interface
REQ-001 The block SHALL have parameter FRAME_W, default 160, frame width in pixels.
REQ-002 The block SHALL have parameter FRAME_H, default 120, frame height in pixels; FRAME_W*FRAME_H SHALL NOT exceed 32768.
REQ-003 clk  input  1  single clock; shared with frame-buffer read port; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to scan the frame buffer.
REQ-006 threshold  input  8  minimum pixel value counted as laser spot.
REQ-007 frame_addr  output  15  frame-buffer read address, raster order: addr = y*FRAME_W + x.
REQ-008 frame_pixel  input  8  frame-buffer read data; valid one cycle after frame_addr is presented.
REQ-009 busy  output  1  high while a scan is in progress.
REQ-010 done  output  1  one-cycle pulse; all result outputs are valid and stable.
REQ-011 spot_found  output  1  at least one pixel >= threshold in the last scan.
REQ-012 spot_x  output  8  column of the brightest qualifying pixel.
REQ-013 spot_y  output  7  row of the brightest qualifying pixel.
REQ-014 spot_peak  output  8  value of the brightest qualifying pixel.
REQ-015 spot_count  output  15  number of pixels >= threshold.
REQ-016 sum_x, sum_y  output  22 each  centroid accumulators (see Configuration).

Function
REQ-017 FSM states: IDLE, SCAN, DRAIN, DONE; IDLE->SCAN on start; SCAN->DRAIN after address N-1 (N=FRAME_W*FRAME_H); DRAIN->DONE; DONE->IDLE unconditionally.
REQ-018 threshold SHALL be latched on the start cycle; changes during the scan SHALL have no effect.
REQ-019 In SCAN, frame_addr SHALL start at 0 and increment by 1 each cycle up to N-1; in IDLE/DRAIN/DONE it SHALL hold 0.
REQ-020 The x/y counters SHALL track frame_addr; x wraps FRAME_W-1 -> 0 with y increment; the compare stage uses x/y delayed one cycle to align with frame_pixel.
REQ-021 A pixel qualifies when frame_pixel >= latched threshold; each qualifying pixel SHALL increment spot_count.
REQ-022 The brightest qualifying pixel SHALL replace the stored peak only when strictly greater; ties keep the earliest pixel in raster order.
REQ-023 With start at cycle t, done SHALL be high in cycle t+N+2 only; busy SHALL be high in cycles t+1 through t+N+1.
REQ-024 start while busy or in DONE SHALL be ignored.
REQ-025 Working accumulators SHALL clear on accepted start; result outputs SHALL update only at entry to DONE and hold until the next DONE.
REQ-026 If no pixel qualifies: spot_found=0, spot_x=0, spot_y=0, spot_peak=0, spot_count=0.
REQ-027 spot_count SHALL NOT wrap: 15 bits covers N <= 32767; with N=32768 it SHALL saturate at 32767.

Reset
REQ-028 rst SHALL force IDLE and set frame_addr, busy, done, spot_found, spot_x, spot_y, spot_peak, spot_count, sum_x, sum_y and all accumulators to 0.
REQ-029 rst asserted mid-scan SHALL abort the scan without producing a done pulse; rst has priority over start.

Configuration
REQ-030 Macro SPOT_CENTROID_EN: when defined, sum_x/sum_y SHALL accumulate the x and y of every qualifying pixel and be published at DONE like the other results.
REQ-031 Without SPOT_CENTROID_EN, sum_x and sum_y SHALL be constant 0 and the accumulator logic SHALL be absent; all other behaviour is unchanged.

Verification
REQ-032 All-zero frame, threshold=16, start -> done at t+19202, spot_found=0, spot_count=0, outputs 0.
REQ-033 Single pixel 200 at (x=37,y=52), threshold=100 -> spot_x=37, spot_y=52, spot_peak=200, spot_count=1; with macro, sum_x=37, sum_y=52.
REQ-034 Pixels 180 at (10,5) and (90,100), threshold=150 -> spot_x=10, spot_y=5 (tie keeps first), spot_count=2; with macro, sum_x=100, sum_y=105.
REQ-035 Pixel == threshold=128 at last address (159,119) -> counted: spot_count=1, spot_x=159, spot_y=119 (DRAIN alignment).
REQ-036 start pulsed again at t+500 and threshold changed mid-scan -> ignored, single done at t+19202, results use original threshold.
REQ-037 rst asserted at t+1000 for one cycle -> no done, all outputs 0 next cycle; new start completes normally.
